// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 device-to-host receiver for the keyboard port.
// Synchronises and de-glitches the PS/2 clock and data lines, deserialises
// 11-bit frames (start, 8 data LSB first, odd parity, stop), and tracks the
// make/break state of one configured Set-2 key for the game flap input.
//
// Ports:
//   iCLK       system clock (50 MHz)
//   iRST       asynchronous active-low reset
//   iPS2_CLK   raw PS/2 clock pin (asynchronous)
//   iPS2_DAT   raw PS/2 data pin (asynchronous)
//   oDATA      last correctly received byte
//   oVALID     one-cycle strobe, oDATA updated
//   oERR       one-cycle strobe, parity/stop/timeout error
//   oKEY_DOWN  level, tracked key currently held
//   oFLAP      one-cycle strobe on the first make of the tracked key
module ps2_key_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 10000,
  parameter logic [7:0]  KEY_CODE   = 8'h29
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oERR,
  output logic       oKEY_DOWN,
  output logic       oFLAP
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT);
  localparam int unsigned BYTE_W   = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Input conditioning registers
  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic                  dat_s_c;
  logic                  fall_c;

  // Receiver state
  state_t            state_q, state_nxt;
  logic [2:0]        bit_cnt_q, bit_cnt_nxt;
  logic [BYTE_W-1:0] shreg_q, shreg_nxt;
  logic              par_q, par_nxt;
  logic [BYTE_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              err_nxt;

  // Inter-fall cycle counter
  logic [CNT_W-1:0]  to_cnt;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic              timeout_c;

  // Decoder prefix flags
  logic              brk_q;
  logic              ext_q;

  // Two-flop synchronisers and clock glitch filter shift register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_sr  <= '1;
      filt_clk <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], iPS2_CLK};
      dat_sync <= {dat_sync[0], iPS2_DAT};
      filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
      // Hysteresis: only a unanimous filter window moves the filtered clock
      if (filt_sr == '0) begin
        filt_clk <= 1'b0;
      end else if (filt_sr == '1) begin
        filt_clk <= 1'b1;
      end
    end
  end

  assign dat_s_c = dat_sync[1];
  assign fall_c  = filt_clk & (filt_sr == '0);

  // Saturating count of cycles since the last sample event
  assign cnt_nxt_c = (to_cnt == CNT_LAST) ? to_cnt : to_cnt + CNT_W'(1);
  assign timeout_c = (state_q != S_IDLE) && !fall_c && (cnt_nxt_c == CNT_LAST);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      to_cnt <= '0;
    end else if (fall_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= cnt_nxt_c;
    end
  end

  // Receiver state register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      oDATA     <= '0;
      oVALID    <= 1'b0;
      oERR      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      shreg_q   <= shreg_nxt;
      par_q     <= par_nxt;
      oDATA     <= data_nxt;
      oVALID    <= valid_nxt;
      oERR      <= err_nxt;
    end
  end

  // Receiver next-state and output logic
  always_comb begin
    state_nxt   = state_q;
    bit_cnt_nxt = bit_cnt_q;
    shreg_nxt   = shreg_q;
    par_nxt     = par_q;
    data_nxt    = oDATA;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A high data line on a fall is not a start bit; ignore it silently
        if (fall_c && !dat_s_c) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (fall_c) begin
          shreg_nxt = {dat_s_c, shreg_q[BYTE_W-1:1]};
          if (bit_cnt_q == 3'd7) begin
            state_nxt = S_PARITY;
          end else begin
            bit_cnt_nxt = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (fall_c) begin
          par_nxt   = dat_s_c;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_c) begin
          state_nxt = S_IDLE;
          if (dat_s_c && (^{shreg_q, par_q})) begin
            data_nxt  = shreg_q;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (timeout_c) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end
  end

  // Make/break decoder, updated on the same edge that raises oVALID
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      oKEY_DOWN <= 1'b0;
      oFLAP     <= 1'b0;
    end else begin
      oFLAP <= 1'b0;
      if (err_nxt) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (valid_nxt) begin
        if (shreg_q == CODE_BREAK) begin
          brk_q <= 1'b1;
        end else if (shreg_q == CODE_EXT) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if ((shreg_q == KEY_CODE) && !ext_q) begin
            if (brk_q) begin
              oKEY_DOWN <= 1'b0;
            end else if (!oKEY_DOWN) begin
              // Typematic repeats arrive with the key already down
              oKEY_DOWN <= 1'b1;
              oFLAP     <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: directed self-checking bench for ps2_key_rx.
// Drives PS/2 frames bit by bit on the pins, counts output strobes from a
// negedge monitor and compares against hand-computed expectations.
module tb_ps2_key_rx;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 300;
  localparam int          HALF       = 30;

  logic       iCLK;
  logic       iRST;
  logic       iPS2_CLK;
  logic       iPS2_DAT;
  logic [7:0] oDATA;
  logic       oVALID;
  logic       oERR;
  logic       oKEY_DOWN;
  logic       oFLAP;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_flap = 0;
  int n_both = 0;
  int last_valid_cyc = 0;
  int last_err_cyc = 0;
  int fall_cyc = 0;

  int v0, e0, f0;

  ps2_key_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT),
    .KEY_CODE   (8'h29)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iPS2_CLK  (iPS2_CLK),
    .iPS2_DAT  (iPS2_DAT),
    .oDATA     (oDATA),
    .oVALID    (oVALID),
    .oERR      (oERR),
    .oKEY_DOWN (oKEY_DOWN),
    .oFLAP     (oFLAP)
  );

  initial iCLK = 1'b0;
  always #10 iCLK = ~iCLK;

  always @(posedge iCLK) cyc = cyc + 1;

  // Strobe monitor: counts high cycles, so a stuck strobe over-counts
  always @(negedge iCLK) begin
    if (oVALID) begin
      n_valid = n_valid + 1;
      last_valid_cyc = cyc;
    end
    if (oERR) begin
      n_err = n_err + 1;
      last_err_cyc = cyc;
    end
    if (oFLAP) n_flap = n_flap + 1;
    if (oVALID && oERR) n_both = n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    v0 = n_valid;
    e0 = n_err;
    f0 = n_flap;
  endtask

  task automatic drive_bit(input logic v, input int half);
    @(negedge iCLK);
    iPS2_DAT = v;
    repeat (half) @(negedge iCLK);
    iPS2_CLK = 1'b0;
    fall_cyc = cyc;
    repeat (half) @(negedge iCLK);
    iPS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par,
                            input logic stop_v, input int half);
    logic par;
    par = (~^b) ^ flip_par;
    drive_bit(1'b0, half);
    for (int i = 0; i < 8; i++) drive_bit(b[i], half);
    drive_bit(par, half);
    drive_bit(stop_v, half);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, HALF);
  endtask

  initial begin
    logic [7:0] part;
    iRST     = 1'b0;
    iPS2_CLK = 1'b1;
    iPS2_DAT = 1'b1;
    repeat (5) @(negedge iCLK);
    chk("rst_data", 32'(oDATA), 32'h0);
    chk("rst_valid", 32'(oVALID), 32'h0);
    chk("rst_err", 32'(oERR), 32'h0);
    chk("rst_keydown", 32'(oKEY_DOWN), 32'h0);
    chk("rst_flap", 32'(oFLAP), 32'h0);
    iRST = 1'b1;
    repeat (5) @(negedge iCLK);

    // Single make of the tracked key at a slower PS/2 clock
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 140);
    chk("make_data", 32'(oDATA), 32'h29);
    chk("make_valid_cnt", 32'(n_valid - v0), 32'd1);
    chk("make_flap_cnt", 32'(n_flap - f0), 32'd1);
    chk("make_err_cnt", 32'(n_err - e0), 32'd0);
    chk("make_keydown", 32'(oKEY_DOWN), 32'd1);
    chk("make_latency", 32'(last_valid_cyc - fall_cyc), 32'(FILTER_LEN + 3));

    // Release, then typematic repeats give exactly one flap
    snap();
    send(8'hF0);
    send(8'h29);
    chk("rel1_keydown", 32'(oKEY_DOWN), 32'd0);
    chk("rel1_flap_cnt", 32'(n_flap - f0), 32'd0);
    snap();
    send(8'h29);
    send(8'h29);
    send(8'h29);
    chk("typ_valid_cnt", 32'(n_valid - v0), 32'd3);
    chk("typ_flap_cnt", 32'(n_flap - f0), 32'd1);
    chk("typ_keydown", 32'(oKEY_DOWN), 32'd1);
    snap();
    send(8'hF0);
    send(8'h29);
    chk("rel2_keydown", 32'(oKEY_DOWN), 32'd0);
    chk("rel2_flap_cnt", 32'(n_flap - f0), 32'd0);
    chk("rel2_valid_cnt", 32'(n_valid - v0), 32'd2);

    // Bad parity: error only, oDATA keeps the last good byte
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, HALF);
    chk("par_err_cnt", 32'(n_err - e0), 32'd1);
    chk("par_valid_cnt", 32'(n_valid - v0), 32'd0);
    chk("par_data", 32'(oDATA), 32'h29);

    // Bad stop bit, then a good make still flaps
    snap();
    send_frame(8'h29, 1'b0, 1'b0, HALF);
    chk("stop_err_cnt", 32'(n_err - e0), 32'd1);
    chk("stop_valid_cnt", 32'(n_valid - v0), 32'd0);
    snap();
    send(8'h29);
    chk("after_stop_flap", 32'(n_flap - f0), 32'd1);
    chk("after_stop_keydown", 32'(oKEY_DOWN), 32'd1);

    // Errors leave the held key alone
    snap();
    send_frame(8'h55, 1'b1, 1'b1, HALF);
    chk("err_keep_err_cnt", 32'(n_err - e0), 32'd1);
    chk("err_keep_keydown", 32'(oKEY_DOWN), 32'd1);

    // Timeout after four data bits, then a clean 0x1C frame
    snap();
    part = 8'h1C;
    drive_bit(1'b0, HALF);
    for (int i = 0; i < 4; i++) drive_bit(part[i], HALF);
    for (int i = 0; i < 2 * TIMEOUT && n_err == e0; i++) @(negedge iCLK);
    chk("to_err_cnt", 32'(n_err - e0), 32'd1);
    chk("to_valid_cnt", 32'(n_valid - v0), 32'd0);
    chk("to_latency", 32'(last_err_cyc - fall_cyc), 32'(FILTER_LEN + 3 + TIMEOUT - 1));
    snap();
    send(8'h1C);
    chk("to_next_data", 32'(oDATA), 32'h1C);
    chk("to_next_valid", 32'(n_valid - v0), 32'd1);
    chk("to_next_err", 32'(n_err - e0), 32'd0);

    // Release, then an extended 0x29 never matches
    send(8'hF0);
    send(8'h29);
    chk("rel3_keydown", 32'(oKEY_DOWN), 32'd0);
    snap();
    send(8'hE0);
    send(8'h29);
    chk("ext_valid_cnt", 32'(n_valid - v0), 32'd2);
    chk("ext_flap_cnt", 32'(n_flap - f0), 32'd0);
    chk("ext_keydown", 32'(oKEY_DOWN), 32'd0);
    snap();
    send(8'h29);
    chk("post_ext_flap", 32'(n_flap - f0), 32'd1);

    // Short low glitch on the PS/2 clock in IDLE
    snap();
    @(negedge iCLK);
    iPS2_CLK = 1'b0;
    repeat (3) @(negedge iCLK);
    iPS2_CLK = 1'b1;
    repeat (40) @(negedge iCLK);
    chk("glitch_strobes", 32'((n_valid - v0) + (n_err - e0) + (n_flap - f0)), 32'd0);
    snap();
    send(8'h1C);
    chk("glitch_next_data", 32'(oDATA), 32'h1C);

    // Reset in the middle of a frame
    snap();
    drive_bit(1'b0, HALF);
    drive_bit(1'b1, HALF);
    drive_bit(1'b0, HALF);
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("midrst_data", 32'(oDATA), 32'h0);
    chk("midrst_keydown", 32'(oKEY_DOWN), 32'd0);
    chk("midrst_strobes", 32'({oVALID, oERR, oFLAP}), 32'd0);
    iRST = 1'b1;
    repeat (5) @(negedge iCLK);
    chk("midrst_no_strobe_cnt", 32'((n_valid - v0) + (n_err - e0) + (n_flap - f0)), 32'd0);
    snap();
    send(8'h29);
    chk("midrst_next_data", 32'(oDATA), 32'h29);
    chk("midrst_next_flap", 32'(n_flap - f0), 32'd1);
    chk("midrst_next_keydown", 32'(oKEY_DOWN), 32'd1);

    chk("valid_err_overlap", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
